// File: rtl/apb_arbiter_2to1_pkg.sv
// Shared types for the 2:1 APB arbiter: FSM encoding, one-hot grant codes, timeout read data.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_t;

  typedef logic [1:0] grant_t;

  localparam grant_t GNT_NONE = 2'b00;
  localparam grant_t GNT_M0   = 2'b01;
  localparam grant_t GNT_M1   = 2'b10;

  localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

  // Round-robin pick: on a tie the master that did not own the last transfer wins.
  function automatic grant_t rr_pick(input logic r0, input logic r1, input grant_t last);
    if (r0 && r1) return (last == GNT_M0) ? GNT_M1 : GNT_M0;
    if (r0) return GNT_M0;
    if (r1) return GNT_M1;
    return GNT_NONE;
  endfunction

endpackage

// File: rtl/apb_arbiter_2to1_if.sv
// APB bus bundle; master modport drives the request side, slave modport answers it.
// Latency: n/a (wiring only).
// Backpressure: pready from the slave side stalls the master side.
interface apb_arbiter_2to1_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/apb_arbiter_2to1_watchdog.sv
// ACCESS-phase wait counter; flags expiry on the LIMIT-th consecutive not-ready ACCESS cycle.
// Latency: expire is combinational from the counter and the run qualifier.
// Backpressure: none; only built when APB_ARB_TIMEOUT_EN is defined.
`ifdef APB_ARB_TIMEOUT_EN
module apb_arb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expire
);
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expire = run & (cnt_q == 8'(LIMIT - 1));
endmodule
`endif

// File: rtl/apb_arbiter_2to1.sv
// Round-robin 2:1 APB arbiter; grant held for one SETUP+ACCESS transfer. Optional: APB_ARB_TIMEOUT_EN.
// Latency: master SETUP at t -> PSEL t+1, PENABLE t+2, earliest pready t+2; one IDLE cycle between transfers.
// Backpressure: shared PREADY stalls the owner; the non-owner sees pready=0 until its own ACCESS.
module apb_arbiter_2to1
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                CLK,
  input  logic                RESETn,
  apb_arbiter_2to1_if.slave   m0,
  apb_arbiter_2to1_if.slave   m1,
  apb_arbiter_2to1_if.master  bus,
  output grant_t              arb_grant,
  output logic                arb_timeout
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 8-bit ACCESS counter (1..255)");
  end

  arb_state_t        state_q, state_d;
  grant_t            owner_q, owner_d;
  grant_t            last_q, last_d;
  grant_t            pick;
  logic              pend0_q, pend0_d, pend1_q, pend1_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_ret;
  logic              req0, req1, in_access, done, expire;

  assign req0      = m0.psel & ~m0.penable;
  assign req1      = m1.psel & ~m1.penable;
  assign in_access = (state_q == ST_ACCESS);
  assign done      = in_access & (bus.pready | expire);

  // A master that lost a tie moves on to its ACCESS phase and drops its
  // SETUP-shaped request; the pending bit keeps its place in the queue.
  assign pick = (state_q == ST_IDLE) ? rr_pick(req0 | pend0_q, req1 | pend1_q, last_q) : GNT_NONE;

`ifdef APB_ARB_TIMEOUT_EN
  apb_arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (CLK),
    .rst_n  (RESETn),
    .clr    (state_q == ST_SETUP),
    .run    (in_access & ~bus.pready),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= ST_IDLE;
      owner_q   <= GNT_NONE;
      last_q    <= GNT_M1;
      pend0_q   <= 1'b0;
      pend1_q   <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      pend0_q   <= pend0_d;
      pend1_q   <= pend1_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pend0_d   = (pend0_q | (req0 & (owner_q != GNT_M0))) & (pick != GNT_M0);
    pend1_d   = (pend1_q | (req1 & (owner_q != GNT_M1))) & (pick != GNT_M1);

    case (state_q)
      ST_IDLE: begin
        if (pick != GNT_NONE) begin
          state_d = ST_SETUP;
          owner_d = pick;
          psel_d  = 1'b1;
          if (pick == GNT_M0) begin
            pwrite_d = m0.pwrite;
            paddr_d  = m0.paddr;
            pwdata_d = m0.pwdata;
          end else begin
            pwrite_d = m1.pwrite;
            paddr_d  = m1.paddr;
            pwdata_d = m1.pwdata;
          end
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (done) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          last_d    = owner_q;
          owner_d   = GNT_NONE;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.psel    = psel_q;
  assign bus.penable = penable_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.paddr   = paddr_q;
  assign bus.pwdata  = pwdata_q;

  assign rdata_ret = expire ? DATA_W'(TIMEOUT_RDATA) : bus.prdata;

  assign m0.pready = in_access & (owner_q == GNT_M0) & (bus.pready | expire);
  assign m1.pready = in_access & (owner_q == GNT_M1) & (bus.pready | expire);
  assign m0.prdata = (owner_q == GNT_M0) ? rdata_ret : '0;
  assign m1.prdata = (owner_q == GNT_M1) ? rdata_ret : '0;

  assign arb_grant   = owner_q;
  assign arb_timeout = expire;

endmodule

// File: tb/tb_apb_arbiter_2to1.sv
// Bench for apb_arbiter_2to1: two standard APB master agents, a wait-state slave and a transfer-order model.
module tb_apb_arbiter_2to1;
  import apb_arb_pkg::*;

  typedef struct packed {
    logic       write;
    logic [4:0] addr;
    logic [7:0] wdata;
  } txn_t;

  typedef struct {
    int         m;
    logic [7:0] rdata;
    int         cyc;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic       write;
    logic [1:0] grant;
    logic       tmo;
  } cpl_t;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  always #5 CLK = ~CLK;

  apb_arbiter_2to1_if m0_if ();
  apb_arbiter_2to1_if m1_if ();
  apb_arbiter_2to1_if bus_if ();
  logic [1:0] arb_grant;
  logic       arb_timeout;

  apb_arbiter_2to1 #(.ADDR_W(5), .DATA_W(8), .TIMEOUT_CYCLES(4)) dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .m0          (m0_if),
    .m1          (m1_if),
    .bus         (bus_if),
    .arb_grant   (arb_grant),
    .arb_timeout (arb_timeout)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int viol = 0;
  int slave_wait = 0;
  int acc_cnt = 0;
  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];
  txn_t mq0[$], mq1[$];
  int   su0[$], su1[$];
  int   mph [2];
  txn_t mcur [2];
  cpl_t cpl[$];
  logic hist_psel [4096];
  logic hist_pen  [4096];
  logic [1:0] hist_gnt [4096];
  logic hist_rdy0 [4096];
  logic hist_rdy1 [4096];
  logic hist_tmo  [4096];

  function automatic txn_t mk_txn(input logic w, input logic [4:0] a, input logic [7:0] d);
    txn_t t;
    t.write = w; t.addr = a; t.wdata = d;
    return t;
  endfunction

  task automatic drive_masters();
    m0_if.psel = (mph[0] != 0); m0_if.penable = (mph[0] == 2);
    m0_if.pwrite = mcur[0].write; m0_if.paddr = mcur[0].addr; m0_if.pwdata = mcur[0].wdata;
    m1_if.psel = (mph[1] != 0); m1_if.penable = (mph[1] == 2);
    m1_if.pwrite = mcur[1].write; m1_if.paddr = mcur[1].addr; m1_if.pwdata = mcur[1].wdata;
  endtask

  task automatic advance(input int m, input logic rdy);
    if (mph[m] == 2 && rdy) mph[m] = 0;
    else if (mph[m] == 1) mph[m] = 2;
    if (mph[m] == 0) begin
      if (m == 0 && mq0.size() > 0) begin mcur[0] = mq0.pop_front(); mph[0] = 1; su0.push_back(cyc); end
      if (m == 1 && mq1.size() > 0) begin mcur[1] = mq1.pop_front(); mph[1] = 1; su1.push_back(cyc); end
    end
  endtask

  task automatic record(input int m, input logic [7:0] rd);
    cpl_t c;
    c.m = m; c.rdata = rd; c.cyc = cyc; c.addr = bus_if.paddr; c.wdata = bus_if.pwdata;
    c.write = bus_if.pwrite; c.grant = arb_grant; c.tmo = arb_timeout;
    cpl.push_back(c);
  endtask

  // One clock: observe at the falling edge, then update agents just after the rising edge.
  task automatic step();
    logic rdy0, rdy1;
    @(negedge CLK);
    rdy0 = m0_if.pready; rdy1 = m1_if.pready;
    hist_psel[cyc & 4095] = bus_if.psel; hist_pen[cyc & 4095] = bus_if.penable;
    hist_gnt[cyc & 4095] = arb_grant; hist_tmo[cyc & 4095] = arb_timeout;
    hist_rdy0[cyc & 4095] = rdy0; hist_rdy1[cyc & 4095] = rdy1;
    if (arb_grant != GNT_M0 && (rdy0 || m0_if.prdata != 8'h00)) viol++;
    if (arb_grant != GNT_M1 && (rdy1 || m1_if.prdata != 8'h00)) viol++;
    if (mph[0] == 2 && rdy0) record(0, m0_if.prdata);
    if (mph[1] == 2 && rdy1) record(1, m1_if.prdata);
    if (bus_if.psel && bus_if.penable && bus_if.pready && bus_if.pwrite) mem[bus_if.paddr] = bus_if.pwdata;
    @(posedge CLK); #1;
    cyc++;
    advance(0, rdy0);
    advance(1, rdy1);
    drive_masters();
    if (bus_if.psel && bus_if.penable) acc_cnt++; else acc_cnt = 0;
    bus_if.pready = bus_if.psel && bus_if.penable && (acc_cnt > slave_wait);
    bus_if.prdata = mem[bus_if.paddr];
  endtask

  task automatic clear_agents();
    mq0.delete(); mq1.delete(); su0.delete(); su1.delete();
    mph[0] = 0; mph[1] = 0;
    drive_masters();
    bus_if.pready = 1'b0; acc_cnt = 0;
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    clear_agents();
    step(); step();
    RESETn = 1'b1;
    cpl.delete(); viol = 0;
  endtask

  task automatic wait_cpl(input int n, input int budget, input string name);
    int k = 0;
    while (cpl.size() < n && k < budget) begin step(); k++; end
    if (cpl.size() < n) begin
      tests++; fails++;
      $display("FAIL %s_wait: %0d completions, required %0d", name, cpl.size(), n);
    end
    step(); step();
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    clear_agents();
    step(); step();
    tests++;
    if ({bus_if.psel, bus_if.penable, bus_if.pwrite} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl: psel/penable/pwrite=%b required 000", {bus_if.psel, bus_if.penable, bus_if.pwrite});
    end
    tests++;
    if ({bus_if.paddr, bus_if.pwdata} !== 13'h0) begin
      fails++; $display("FAIL reset_data: paddr=%h pwdata=%h required 0", bus_if.paddr, bus_if.pwdata);
    end
    tests++;
    if (arb_grant !== GNT_NONE || arb_timeout !== 1'b0) begin
      fails++; $display("FAIL reset_grant: grant=%b timeout=%b required 00/0", arb_grant, arb_timeout);
    end
    RESETn = 1'b1;
    step(); step();
    tests++;
    if (arb_grant !== GNT_NONE || bus_if.psel !== 1'b0 || m0_if.pready !== 1'b0 || m1_if.pready !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: grant=%b psel=%b p0=%b p1=%b required all 0",
                        arb_grant, bus_if.psel, m0_if.pready, m1_if.pready);
    end
  endtask

  task automatic test_single_write();
    int t;
    do_reset(); slave_wait = 0;
    mq0.push_back(mk_txn(1'b1, 5'h03, 8'hA5));
    wait_cpl(1, 20, "single_write");
    t = (su0.size() > 0) ? su0[0] : 0;
    tests++;
    if (hist_psel[t] !== 1'b0 || hist_psel[t+1] !== 1'b1 || hist_pen[t+1] !== 1'b0) begin
      fails++; $display("FAIL sw_psel: psel(t,t+1)=%b%b pen(t+1)=%b required 010", hist_psel[t], hist_psel[t+1], hist_pen[t+1]);
    end
    tests++;
    if (hist_pen[t+2] !== 1'b1 || hist_gnt[t+1] !== GNT_M0) begin
      fails++; $display("FAIL sw_penable: pen(t+2)=%b grant(t+1)=%b required 1/01", hist_pen[t+2], hist_gnt[t+1]);
    end
    if (cpl.size() >= 1) begin
      tests++;
      if (cpl[0].cyc !== t + 2) begin
        fails++; $display("FAIL sw_latency: pready cycle %0d required %0d", cpl[0].cyc, t + 2);
      end
      tests++;
      if ({cpl[0].write, cpl[0].addr, cpl[0].wdata} !== {1'b1, 5'h03, 8'hA5} || cpl[0].grant !== GNT_M0) begin
        fails++; $display("FAIL sw_bus: w=%b a=%h d=%h g=%b required 1/03/a5/01",
                          cpl[0].write, cpl[0].addr, cpl[0].wdata, cpl[0].grant);
      end
    end
  endtask

  task automatic test_tie();
    do_reset(); slave_wait = 0;
    mq0.push_back(mk_txn(1'b0, 5'h07, 8'h00));
    mq1.push_back(mk_txn(1'b0, 5'h08, 8'h00));
    wait_cpl(2, 30, "tie");
    if (cpl.size() >= 2) begin
      tests++;
      if (cpl[0].m !== 0 || cpl[1].m !== 1) begin
        fails++; $display("FAIL tie_order: served %0d then %0d required 0 then 1", cpl[0].m, cpl[1].m);
      end
      tests++;
      if (cpl[1].addr !== 5'h08 || cpl[1].cyc - cpl[0].cyc !== 3) begin
        fails++; $display("FAIL tie_second: addr=%h gap=%0d required 08/3", cpl[1].addr, cpl[1].cyc - cpl[0].cyc);
      end
    end
    tests++;
    if (viol !== 0) begin
      fails++; $display("FAIL tie_stall: %0d non-owner pready/prdata events required 0", viol);
    end
  endtask

  task automatic test_wait_read();
    int t;
    do_reset(); slave_wait = 3;
    mem[5'h1F] = 8'h5C;
    mq1.push_back(mk_txn(1'b0, 5'h1F, 8'h00));
    wait_cpl(1, 30, "wait_read");
    t = (su1.size() > 0) ? su1[0] : 0;
    if (cpl.size() >= 1) begin
      tests++;
      if (cpl[0].cyc !== t + 5 || cpl[0].m !== 1) begin
        fails++; $display("FAIL wr_latency: master %0d at cycle %0d required 1 at %0d", cpl[0].m, cpl[0].cyc, t + 5);
      end
      tests++;
      if (cpl[0].rdata !== 8'h5C) begin
        fails++; $display("FAIL wr_rdata: %h required 5c", cpl[0].rdata);
      end
    end
    tests++;
    if (hist_rdy1[t+2] !== 1'b0 || hist_rdy1[t+3] !== 1'b0 || hist_rdy1[t+4] !== 1'b0 || viol !== 0) begin
      fails++; $display("FAIL wr_stall: rdy1(t+2..4)=%b%b%b viol=%0d required 000/0",
                        hist_rdy1[t+2], hist_rdy1[t+3], hist_rdy1[t+4], viol);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g;
    do_reset(); slave_wait = 0;
    for (int i = 0; i < 3; i++) begin
      mq0.push_back(mk_txn(1'b0, 5'(i), 8'h00));
      mq1.push_back(mk_txn(1'b0, 5'(i + 16), 8'h00));
    end
    wait_cpl(6, 100, "alternate");
    for (int i = 0; i < 6 && i < cpl.size(); i++) begin
      exp_g = (i % 2 == 0) ? GNT_M0 : GNT_M1;
      tests++;
      if (cpl[i].grant !== exp_g) begin
        fails++; $display("FAIL alt_grant[%0d]: %b required %b", i, cpl[i].grant, exp_g);
      end
    end
  endtask

  task automatic test_random(input int iter);
    txn_t e0[$], e1[$], ex[$];
    int   exm[$];
    int   n0, n1, i0, i1, last, pick;
    txn_t t;
    logic [7:0] exp_d;
    do_reset();
    slave_wait = $urandom_range(0, 2);
    n0 = $urandom_range(1, 5); n1 = $urandom_range(1, 5);
    for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < n0; i++) begin
      t = mk_txn(1'($urandom), 5'($urandom), 8'($urandom)); e0.push_back(t); mq0.push_back(t);
    end
    for (int i = 0; i < n1; i++) begin
      t = mk_txn(1'($urandom), 5'($urandom), 8'($urandom)); e1.push_back(t); mq1.push_back(t);
    end
    // Both masters stay busy: strict alternation from m0 while both have work, then the rest.
    i0 = 0; i1 = 0; last = 1;
    while (i0 < n0 || i1 < n1) begin
      if (i0 < n0 && i1 < n1) pick = (last == 0) ? 1 : 0;
      else pick = (i0 < n0) ? 0 : 1;
      if (pick == 0) begin ex.push_back(e0[i0]); i0++; end
      else begin ex.push_back(e1[i1]); i1++; end
      exm.push_back(pick); last = pick;
    end
    wait_cpl(n0 + n1, 20 * (n0 + n1) + 20, "random");
    for (int i = 0; i < ex.size() && i < cpl.size(); i++) begin
      exp_d = ex[i].write ? ex[i].wdata : ref_mem[ex[i].addr];
      if (ex[i].write) ref_mem[ex[i].addr] = ex[i].wdata;
      tests++;
      if (cpl[i].m !== exm[i] || cpl[i].addr !== ex[i].addr || cpl[i].write !== ex[i].write ||
          (ex[i].write ? cpl[i].wdata : cpl[i].rdata) !== exp_d ||
          cpl[i].grant !== (exm[i] == 0 ? GNT_M0 : GNT_M1)) begin
        fails++; $display("FAIL rnd%0d_txn[%0d]: m=%0d a=%h w=%b d=%h g=%b required m=%0d a=%h w=%b d=%h",
                          iter, i, cpl[i].m, cpl[i].addr, cpl[i].write,
                          ex[i].write ? cpl[i].wdata : cpl[i].rdata, cpl[i].grant,
                          exm[i], ex[i].addr, ex[i].write, exp_d);
      end
      if (i > 0) begin
        tests++;
        if (cpl[i].cyc - cpl[i-1].cyc !== slave_wait + 3) begin
          fails++; $display("FAIL rnd%0d_gap[%0d]: %0d cycles required %0d", iter, i, cpl[i].cyc - cpl[i-1].cyc, slave_wait + 3);
        end
      end
    end
    tests++;
    if (viol !== 0) begin
      fails++; $display("FAIL rnd%0d_stall: %0d non-owner events required 0", iter, viol);
    end
  endtask

  task automatic test_reset_mid();
    int n_before;
    do_reset(); slave_wait = 0;
    mq0.push_back(mk_txn(1'b0, 5'h01, 8'h00));
    wait_cpl(1, 20, "mid_pre");
    slave_wait = 10;
    mq1.push_back(mk_txn(1'b1, 5'h02, 8'h3C));
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus_if.penable) break;
    end
    n_before = cpl.size();
    #2 RESETn = 1'b0;
    #1;
    tests++;
    if (bus_if.psel !== 1'b0 || bus_if.penable !== 1'b0 || arb_grant !== GNT_NONE || m1_if.pready !== 1'b0) begin
      fails++; $display("FAIL mid_reset_drop: psel=%b pen=%b grant=%b p1=%b required 0/0/00/0",
                        bus_if.psel, bus_if.penable, arb_grant, m1_if.pready);
    end
    tests++;
    if (n_before !== 1) begin
      fails++; $display("FAIL mid_reset_cpl: %0d completions before reset required 1", n_before);
    end
    do_reset(); slave_wait = 0;
    mq0.push_back(mk_txn(1'b0, 5'h04, 8'h00));
    mq1.push_back(mk_txn(1'b0, 5'h05, 8'h00));
    wait_cpl(2, 30, "mid_post");
    if (cpl.size() >= 2) begin
      tests++;
      if (cpl[0].m !== 0 || cpl[1].m !== 1) begin
        fails++; $display("FAIL mid_reset_tie: served %0d then %0d required 0 then 1", cpl[0].m, cpl[1].m);
      end
    end
  endtask

  task automatic test_timeout();
    int t, ntmo;
    logic [7:0] exp_d;
    do_reset(); slave_wait = 1000;
`ifdef APB_ARB_TIMEOUT_EN
    mq0.push_back(mk_txn(1'b0, 5'h0A, 8'h00));
    mq0.push_back(mk_txn(1'b0, 5'h0B, 8'h00));
    wait_cpl(2, 40, "timeout");
    t = (su0.size() > 0) ? su0[0] : 0;
    if (cpl.size() >= 2) begin
      tests++;
      if (cpl[0].cyc !== t + 5 || cpl[0].rdata !== 8'hFF || cpl[0].tmo !== 1'b1) begin
        fails++; $display("FAIL tmo_first: cycle %0d rdata %h tmo %b required %0d/ff/1",
                          cpl[0].cyc, cpl[0].rdata, cpl[0].tmo, t + 5);
      end
      tests++;
      if (cpl[1].cyc - cpl[0].cyc !== 6 || cpl[1].rdata !== 8'hFF) begin
        fails++; $display("FAIL tmo_second: gap %0d rdata %h required 6/ff", cpl[1].cyc - cpl[0].cyc, cpl[1].rdata);
      end
      ntmo = 0;
      for (int c = t; c <= cpl[1].cyc + 1; c++) if (hist_tmo[c] === 1'b1) ntmo++;
      tests++;
      if (ntmo !== 2 || hist_psel[cpl[0].cyc + 1] !== 1'b0) begin
        fails++; $display("FAIL tmo_pulse: %0d pulse cycles, psel after=%b required 2/0", ntmo, hist_psel[cpl[0].cyc + 1]);
      end
    end
`else
    mq0.push_back(mk_txn(1'b0, 5'h0A, 8'h00));
    exp_d = mem[5'h0A];
    ntmo = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (arb_timeout !== 1'b0) ntmo++;
    end
    tests++;
    if (cpl.size() !== 0 || ntmo !== 0 || bus_if.penable !== 1'b1) begin
      fails++; $display("FAIL no_tmo_wait: cpl=%0d tmo=%0d pen=%b required 0/0/1", cpl.size(), ntmo, bus_if.penable);
    end
    slave_wait = 0;
    wait_cpl(1, 10, "no_tmo");
    t = 0;
    if (cpl.size() >= 1) begin
      tests++;
      if (cpl[0].rdata !== exp_d || cpl[0].tmo !== 1'b0) begin
        fails++; $display("FAIL no_tmo_done: rdata %h tmo %b required %h/0", cpl[0].rdata, cpl[0].tmo, exp_d);
      end
    end
`endif
  endtask

  initial begin
    mph[0] = 0; mph[1] = 0;
    mcur[0] = '0; mcur[1] = '0;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    drive_masters();
    bus_if.pready = 1'b0;
    bus_if.prdata = 8'h00;
    test_reset();
    test_single_write();
    test_tie();
    test_wait_read();
    test_alternate();
    for (int i = 0; i < 5; i++) test_random(i);
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "bench time limit");
  end

endmodule
